// File: rtl/reg_write_sequencer_pkg.sv
// Shared definitions for the register-bank write sequencer: bank map, FSM states
// and the header legality rule.
package reg_write_sequencer_pkg;

  localparam int NUM_REGS = 11;

  typedef enum int {
    REG_CTRL0 = 0,
    REG_CTRL1 = 1,
    REG_CTRL2 = 2,
    REG_DATA1 = 3,
    REG_DATA2 = 4,
    REG_DATA3 = 5,
    REG_DATA4 = 6,
    REG_DATA5 = 7,
    REG_DATA6 = 8,
    REG_DATA7 = 9,
    REG_DATA8 = 10
  } reg_index_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_WAIT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  // A burst must start inside the bank and must not run past its last register.
  function automatic logic headerIsValid(input logic [7:0] hdr);
    logic [4:0] addr;
    logic [4:0] len;
    logic [4:0] limit;
    addr  = {1'b0, hdr[7:4]};
    len   = {1'b0, hdr[3:0]} + 5'd1;
    limit = 5'(NUM_REGS);
    return (addr < limit) && ((addr + len) <= limit);
  endfunction

endpackage

// File: rtl/reg_write_sequencer.sv
// Byte-stream front end for the output register bank: a header sets start address and
// burst length, then each data byte is written with a setup / strobe / hold sequence.
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          data,
  output logic [NUM_REGS-1:0] register_select,
  output logic                busy,
  output logic                err
);

  localparam int STB_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic [7:0]          r_data;
  logic [NUM_REGS-1:0] r_select;
  logic                r_busy;
  logic                r_err;
  logic                r_inReady;
  logic [3:0]          r_addr;
  logic [4:0]          r_remaining;
  logic [STB_W-1:0]    r_strobeCnt;
  logic [TMO_W-1:0]    r_tmoCnt;

  logic                w_accept;
  logic                w_hdrValid;
  logic [4:0]          w_hdrLen;

  assign w_accept   = in_valid && r_inReady;
  assign w_hdrValid = headerIsValid(in_byte);
  assign w_hdrLen   = {1'b0, in_byte[3:0]} + 5'd1;

  // All outputs are registered so the latch bank sees glitch-free select and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_select    <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_inReady   <= 1'b1;
      r_addr      <= '0;
      r_remaining <= '0;
      r_strobeCnt <= '0;
      r_tmoCnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_hdrValid) begin
              r_err       <= 1'b0;
              r_addr      <= in_byte[7:4];
              r_remaining <= w_hdrLen;
              r_tmoCnt    <= '0;
              r_busy      <= 1'b1;
              r_state     <= ST_DATA_WAIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_DATA_WAIT: begin
          if (w_accept) begin
            r_data      <= in_byte;
            r_tmoCnt    <= '0;
            r_inReady   <= 1'b0;
            r_state     <= ST_SETUP;
          end else if (r_tmoCnt == TMO_LAST) begin
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_tmoCnt    <= r_tmoCnt + 1'b1;
          end
        end
        ST_SETUP: begin
          r_select    <= NUM_REGS'(1) << r_addr;
          r_strobeCnt <= '0;
          r_state     <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_strobeCnt == STB_LAST) begin
            r_select <= '0;
            r_state  <= ST_HOLD;
          end else begin
            r_strobeCnt <= r_strobeCnt + 1'b1;
          end
        end
        ST_HOLD: begin
          r_addr      <= r_addr + 4'd1;
          r_remaining <= r_remaining - 5'd1;
          r_inReady   <= 1'b1;
          if (r_remaining == 5'd1) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmoCnt <= '0;
            r_state  <= ST_DATA_WAIT;
          end
        end
        default: begin
          r_select  <= '0;
          r_busy    <= 1'b0;
          r_inReady <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = r_inReady;
  assign data            = r_data;
  assign register_select = r_select;
  assign busy            = r_busy;
  assign err             = r_err;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed and randomized bench for reg_write_sequencer; expected bank writes come from
// a queue-based model of header/burst rules, observed writes from a select-pulse monitor.
module tb_reg_write_sequencer;
  import reg_write_sequencer_pkg::*;

  localparam int STROBE = 2;
  localparam int TMO    = 255;
  localparam int GAP    = 3 + STROBE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          in_byte = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          data;
  logic [NUM_REGS-1:0] register_select;
  logic                busy;
  logic                err;

  reg_write_sequencer #(.STROBE_CYCLES(STROBE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data(data),
    .register_select(register_select),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int data;
    int len;
    int start;
    bit ok;
  } pulse_t;

  typedef struct {
    int idx;
    int data;
    int acc;
  } write_t;

  pulse_t     obsQ[$];
  write_t     expQ[$];
  int         modelBank[NUM_REGS];
  int         obsBank[NUM_REGS];
  int         lastData = 0;
  int         acceptCyc[16];
  logic [7:0] stimBytes[16];
  int         nChecks = 0;
  int         nFails = 0;

  // Monitor: turns each select pulse into one observed write with width, start edge,
  // and whether data was stable the cycle before, during and after the pulse.
  logic [NUM_REGS-1:0] prevSel = '0;
  logic [7:0]          prevData = '0;
  int                  curIdx, curData, curLen, curStart;
  bit                  curOk;
  always @(negedge clk) begin
    if (register_select != '0) begin
      if (prevSel == '0) begin
        curIdx = -1;
        for (int k = NUM_REGS - 1; k >= 0; k--) if (register_select[k]) curIdx = k;
        curData  = int'(data);
        curLen   = 1;
        curStart = cyc + 1;
        curOk    = (prevData == data) && $onehot(register_select);
      end else begin
        curLen++;
        if (register_select != prevSel || int'(data) != curData || !$onehot(register_select))
          curOk = 1'b0;
      end
    end else if (prevSel != '0) begin
      if (int'(data) != curData) curOk = 1'b0;
      obsQ.push_back('{curIdx, curData, curLen, curStart, curOk});
    end
    prevSel  = register_select;
    prevData = data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until the sequencer takes it; returns the accepting edge.
  task automatic sendByte(input logic [7:0] b, output int acc);
    int waited;
    waited   = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checkOutput("sendReady", 32'(in_ready), 32'(1));
      acc = -1;
    end else begin
      tick();
      acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic expectWrite(input int idx, input logic [7:0] b, input int acc);
    write_t w;
    w.idx  = idx;
    w.data = int'(b);
    w.acc  = acc;
    expQ.push_back(w);
    modelBank[idx] = int'(b);
    lastData = int'(b);
  endtask

  task automatic waitIdle(input string tag);
    int w;
    w = 0;
    while (busy && w < 100) begin
      tick();
      w++;
    end
    checkOutput(tag, 32'(busy), 32'(0));
  endtask

  task automatic waitReady(input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    checkOutput(tag, 32'(in_ready), 32'(1));
  endtask

  task automatic verifyWrites(input string tag);
    write_t e;
    pulse_t p;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_present"}, 32'(obsQ.size() > 0), 32'(1));
      if (obsQ.size() > 0) begin
        p = obsQ.pop_front();
        checkOutput({tag, "_idx"}, 32'(p.idx), 32'(e.idx));
        checkOutput({tag, "_data"}, 32'(p.data), 32'(e.data));
        checkOutput({tag, "_len"}, 32'(p.len), 32'(STROBE));
        checkOutput({tag, "_stable"}, 32'(p.ok), 32'(1));
        checkOutput({tag, "_latency"}, 32'(p.start), 32'(e.acc + 2));
        if (p.idx >= 0 && p.idx < NUM_REGS) obsBank[p.idx] = p.data;
      end
    end
    checkOutput({tag, "_noExtra"}, 32'(obsQ.size()), 32'(0));
  endtask

  // Send one header and, if the model deems it legal, a full burst from stimBytes.
  task automatic applyStimulus(input logic [7:0] hdr, input int maxGap, input string tag);
    int  a, n, acc;
    bit  legal;
    a     = int'(hdr[7:4]);
    n     = int'(hdr[3:0]) + 1;
    legal = (a < NUM_REGS) && (a + n <= NUM_REGS);
    sendByte(hdr, acc);
    if (!legal) begin
      checkOutput({tag, "_hdrErr"}, 32'(err), 32'(1));
      repeat (4) tick();
      checkOutput({tag, "_hdrIdle"}, 32'(busy), 32'(0));
      checkOutput({tag, "_noWrite"}, 32'(obsQ.size()), 32'(0));
    end else begin
      checkOutput({tag, "_hdrOk"}, 32'(err), 32'(0));
      checkOutput({tag, "_hdrBusy"}, 32'(busy), 32'(1));
      for (int i = 0; i < n; i++) begin
        sendByte(stimBytes[i], acc);
        acceptCyc[i] = acc;
        expectWrite(a + i, stimBytes[i], acc);
        if (maxGap > 0) repeat ($urandom_range(0, maxGap)) tick();
      end
      waitIdle({tag, "_idle"});
      checkOutput({tag, "_errClear"}, 32'(err), 32'(0));
      verifyWrites(tag);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int     acc;
    pulse_t p;
    for (int i = 0; i < NUM_REGS; i++) begin
      modelBank[i] = -1;
      obsBank[i]   = -1;
    end

    // Reset and idle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("t1_data", 32'(data), 32'(0));
    checkOutput("t1_select", 32'(register_select), 32'(0));
    checkOutput("t1_busy", 32'(busy), 32'(0));
    checkOutput("t1_err", 32'(err), 32'(0));
    checkOutput("t1_ready", 32'(in_ready), 32'(1));

    // Single write to CTRL0 with handshake timing.
    sendByte(8'h00, acc);
    checkOutput("t2_hdrBusy", 32'(busy), 32'(1));
    sendByte(8'hA5, acc);
    expectWrite(REG_CTRL0, 8'hA5, acc);
    checkOutput("t2_dataLatched", 32'(data), 32'(8'hA5));
    repeat (3) tick();
    checkOutput("t2_readyLowInHold", 32'(in_ready), 32'(0));
    tick();
    checkOutput("t2_readyBack", 32'(in_ready), 32'(1));
    checkOutput("t2_busyFell", 32'(busy), 32'(0));
    verifyWrites("t2");

    // Full DATA1..DATA8 burst with in_valid held.
    for (int i = 0; i < 8; i++) stimBytes[i] = 8'(1 << i);
    applyStimulus(8'h37, 0, "t3");
    for (int i = 1; i < 8; i++)
      checkOutput("t3_spacing", 32'(acceptCyc[i] - acceptCyc[i-1]), 32'(GAP));
    for (int i = 0; i < 8; i++)
      checkOutput("t3_bank", 32'(obsBank[REG_DATA1 + i]), 32'(stimBytes[i]));

    // Illegal headers, then a legal one clears err.
    applyStimulus(8'hB0, 0, "t4a");
    applyStimulus(8'h84, 0, "t4b");
    stimBytes[0] = 8'h5A;
    applyStimulus(8'h10, 0, "t4c");

    // Timeout in the middle of a two-byte burst.
    sendByte(8'h01, acc);
    checkOutput("t5_hdrOk", 32'(err), 32'(0));
    sendByte(8'h3C, acc);
    expectWrite(REG_CTRL0, 8'h3C, acc);
    waitReady("t5_waitReady");
    repeat (TMO - 1) tick();
    checkOutput("t5_stillWaiting", 32'(busy), 32'(1));
    tick();
    checkOutput("t5_timedOutIdle", 32'(busy), 32'(0));
    checkOutput("t5_timedOutErr", 32'(err), 32'(1));
    verifyWrites("t5");

    // Reset during the strobe of the second byte of a 4-byte burst.
    sendByte(8'h43, acc);
    checkOutput("t6_hdrOk", 32'(err), 32'(0));
    sendByte(8'hC3, acc);
    expectWrite(REG_DATA2, 8'hC3, acc);
    waitReady("t6_waitReady");
    verifyWrites("t6a");
    sendByte(8'h7E, acc);
    tick();
    checkOutput("t6_selHigh", 32'(register_select), 32'(1) << REG_DATA3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lastData = 0;
    checkOutput("t6_selDropped", 32'(register_select), 32'(0));
    checkOutput("t6_busy", 32'(busy), 32'(0));
    checkOutput("t6_ready", 32'(in_ready), 32'(1));
    checkOutput("t6_data", 32'(data), 32'(0));
    repeat (10) tick();
    checkOutput("t6_truncPulse", 32'(obsQ.size()), 32'(1));
    if (obsQ.size() > 0) begin
      p = obsQ.pop_front();
      checkOutput("t6_truncLen", 32'(p.len), 32'(1));
      checkOutput("t6_truncIdx", 32'(p.idx), 32'(REG_DATA3));
    end
    checkOutput("t6_stillIdle", 32'(busy), 32'(0));

    // Randomized bursts, mostly legal, with random gaps between bytes.
    for (int it = 0; it < 25; it++) begin
      logic [7:0] h;
      int         a, l;
      if ($urandom_range(0, 9) < 7) begin
        a = int'($urandom_range(0, NUM_REGS - 1));
        l = int'($urandom_range(1, NUM_REGS - a));
        h = {4'(a), 4'(l - 1)};
      end else begin
        h = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) stimBytes[i] = 8'($urandom);
      applyStimulus(h, 7, "rnd");
    end

    for (int i = 0; i < NUM_REGS; i++)
      checkOutput("bank", 32'(obsBank[i]), 32'(modelBank[i]));
    checkOutput("dataRetained", 32'(data), 32'(lastData));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
